// File: rtl/btn_click_classifier.sv
// btn_click_classifier: turns single-cycle debounced press pulses into
// single / double / triple click gestures using a sliding inter-click window.
// Each classification is reported as a registered one-cycle pulse.
module btn_click_classifier #(
  parameter int WINDOW_COUNT = 30_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn,
  output logic       o_single,
  output logic       o_double,
  output logic       o_triple,
  output logic       o_busy,
  output logic [1:0] o_state
);

  localparam int CNT_W = (WINDOW_COUNT > 2) ? $clog2(WINDOW_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ONE    = 2'd1,
    TWO    = 2'd2,
    UNUSED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             single_d, double_d, triple_d;
  logic             timeout;

  // The window has expired once the counter sits on its last value; it is
  // never advanced past that point, so it cannot wrap.
  assign timeout = (cnt_q == CNT_LAST);

  // Next-state, counter and pulse decode; a click always beats a timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    triple_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_btn) state_d = ONE;
      end
      ONE: begin
        if (i_btn) begin
          state_d = TWO;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d  = IDLE;
          cnt_d    = '0;
          single_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      TWO: begin
        if (i_btn) begin
          state_d  = IDLE;
          cnt_d    = '0;
          triple_d = 1'b1;
        end else if (timeout) begin
          state_d  = IDLE;
          cnt_d    = '0;
          double_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        // Unused encoding recovers to IDLE silently.
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, window counter and registered gesture pulses; reset drops any
  // gesture in progress without emitting a pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      o_single <= 1'b0;
      o_double <= 1'b0;
      o_triple <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      o_single <= single_d;
      o_double <= double_d;
      o_triple <= triple_d;
    end
  end

  // Status outputs decode the state register only.
  assign o_busy  = (state_q != IDLE);
  assign o_state = state_q;

endmodule

// File: tb/tb_btn_click_classifier.sv
// Self-checking bench for btn_click_classifier (WINDOW_COUNT = 20).
// Reference model: remembers how many clicks belong to the current gesture
// and the clock edge of the most recent click; a gesture closes when W
// edges pass without a click, or immediately on the third click.
module tb_btn_click_classifier;

  localparam int W = 20;

  logic       clk;
  logic       rst;
  logic       i_btn;
  logic       o_single, o_double, o_triple, o_busy;
  logic [1:0] o_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int   m_clicks;
  int   m_last_edge;
  int   edge_n;
  logic exp_s, exp_d, exp_t;

  btn_click_classifier #(.WINDOW_COUNT(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_btn    (i_btn),
    .o_single (o_single),
    .o_double (o_double),
    .o_triple (o_triple),
    .o_busy   (o_busy),
    .o_state  (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".single"}, {7'd0, o_single}, {7'd0, exp_s});
    check({tag, ".double"}, {7'd0, o_double}, {7'd0, exp_d});
    check({tag, ".triple"}, {7'd0, o_triple}, {7'd0, exp_t});
    check({tag, ".busy"},   {7'd0, o_busy},   {7'd0, 1'(m_clicks != 0)});
    check({tag, ".state"},  {6'd0, o_state},  8'(m_clicks));
  endtask

  task automatic model_clear();
    m_clicks = 0;
    exp_s = 1'b0;
    exp_d = 1'b0;
    exp_t = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, advance the model at
  // the rising edge, compare just after it.
  task automatic step(input logic b, input logic r, input string tag);
    @(negedge clk);
    i_btn = b;
    rst   = r;
    if (!r) begin
      // Reset acts without waiting for a clock edge.
      model_clear();
      #1 check_all({tag, ".async"});
    end
    @(posedge clk);
    edge_n++;
    exp_s = 1'b0;
    exp_d = 1'b0;
    exp_t = 1'b0;
    if (!r) begin
      model_clear();
    end else if (b) begin
      if (m_clicks == 2) begin
        exp_t = 1'b1;
        m_clicks = 0;
      end else begin
        m_clicks++;
        m_last_edge = edge_n;
      end
    end else if (m_clicks != 0 && (edge_n - m_last_edge) == W) begin
      if (m_clicks == 1) exp_s = 1'b1;
      else               exp_d = 1'b1;
      m_clicks = 0;
    end
    #1 check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, tag);
  endtask

  initial begin
    int sum_single;
    int sum_double;
    int sum_triple;
    edge_n      = 0;
    m_last_edge = 0;
    model_clear();
    i_btn = 1'b0;
    rst   = 1'b0;

    // 1: reset held for three cycles, then released
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "reset");
    idle(2, "post_reset");

    // 2: single click
    step(1'b1, 1'b1, "single");
    idle(25, "single");

    // 3: double click, clicks 10 edges apart
    step(1'b1, 1'b1, "double");
    idle(9, "double");
    step(1'b1, 1'b1, "double");
    idle(30, "double");

    // 4: triple click with 19-edge gaps, then quiet
    step(1'b1, 1'b1, "triple");
    idle(18, "triple");
    step(1'b1, 1'b1, "triple");
    idle(18, "triple");
    step(1'b1, 1'b1, "triple");
    idle(25, "triple_quiet");

    // 5: second click lands exactly on the timeout edge
    step(1'b1, 1'b1, "boundary");
    idle(19, "boundary");
    step(1'b1, 1'b1, "boundary");
    idle(25, "boundary");

    // 6: reset in the middle of a gesture, then a fresh single
    step(1'b1, 1'b1, "mid_reset");
    idle(4, "mid_reset");
    step(1'b0, 1'b0, "mid_reset");
    step(1'b0, 1'b0, "mid_reset");
    idle(25, "mid_reset");
    step(1'b1, 1'b1, "fresh_single");
    idle(25, "fresh_single");

    // 7: button held high across cycles counts every high cycle
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "held3");
    idle(5, "held3");
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, "held2");
    idle(25, "held2");

    // 8: random click trains with occasional resets
    sum_single = 0;
    sum_double = 0;
    sum_triple = 0;
    for (int i = 0; i < 1500; i++) begin
      logic b;
      logic r;
      b = ($urandom_range(0, 99) < 7);
      r = ($urandom_range(0, 399) != 0);
      step(b, r, "random");
      sum_single += int'(exp_s);
      sum_double += int'(exp_d);
      sum_triple += int'(exp_t);
    end
    $display("random phase: %0d single, %0d double, %0d triple gestures",
             sum_single, sum_double, sum_triple);
    idle(25, "drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
